// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
package mult_arbiter_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_multiplier_4bit.sv
// Combinational unsigned 4x4 multiplier, product split into nibbles.
module multiplier_4bit
  import mult_arbiter_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] product_low,
  output logic [OP_W-1:0] product_high
);

  logic [PROD_W-1:0] product;

  always_comb begin
    product      = PROD_W'(a) * PROD_W'(b);
    product_low  = product[OP_W-1:0];
    product_high = product[PROD_W-1:OP_W];
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier between two
// requesters; operands are captured, the product registered and returned.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter bit          PRIO_INIT = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic [1:0]        rsp_ready,
  output logic [PROD_W-1:0] rsp_product,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic              prio_q;
  logic              owner_q;
  logic [OP_W-1:0]   a_q, b_q;
  logic [PROD_W-1:0] product_q;
  logic [CNT_W-1:0]  op_count_q;

  logic              grant_valid;
  logic              grant;
  logic              accept;
  logic              rsp_hs;
  logic [OP_W-1:0]   mul_low, mul_high;

  // Priority only breaks ties; a lone requester always wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = prio_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept = (state_q == StIdle) & grant_valid;
  assign rsp_hs = (state_q == StResp) & rsp_ready[owner_q];

  multiplier_4bit u_mul (
    .a            (a_q),
    .b            (b_q),
    .product_low  (mul_low),
    .product_high (mul_high)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  state_d = StResp;
      StResp:  if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready  = (state_q == StIdle) & grant_valid & ~grant;
    req1_ready  = (state_q == StIdle) & grant_valid & grant;
    rsp0_valid  = (state_q == StResp) & ~owner_q;
    rsp1_valid  = (state_q == StResp) & owner_q;
    busy        = (state_q != StIdle);
    rsp_product = product_q;
    op_count    = op_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= PRIO_INIT;
      owner_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      product_q  <= '0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= grant;
        a_q     <= grant ? req1_a : req0_a;
        b_q     <= grant ? req1_b : req0_b;
      end
      if (state_q == StCalc) begin
        product_q <= {mul_high, mul_low};
      end
      if (rsp_hs) begin
        op_count_q <= op_count_q + CNT_W'(1);
        prio_q     <= ~owner_q;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mult_arbiter;

  localparam bit PRIO_INIT = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_product;
  logic       busy;
  logic [7:0] op_count;

  logic       r0_ready2, r1_ready2, s0_valid2, s1_valid2, busy2;
  logic [7:0] product2;
  logic [1:0] op_count2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: an op in flight with its age in cycles since acceptance.
  int m_owner, m_age, m_a, m_b, m_last, m_prio, m_count;
  bit l_rdy0, l_rdy1;

  typedef struct {
    int         who;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  mult_arbiter #(.PRIO_INIT(PRIO_INIT), .CNT_W(8)) u_dut (
    .clk (clk), .rst (rst),
    .req0_valid (req0_valid), .req0_a (req0_a), .req0_b (req0_b), .req0_ready (req0_ready),
    .req1_valid (req1_valid), .req1_a (req1_a), .req1_b (req1_b), .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid), .rsp1_valid (rsp1_valid), .rsp_ready (rsp_ready),
    .rsp_product (rsp_product), .busy (busy), .op_count (op_count)
  );

  mult_arbiter #(.PRIO_INIT(PRIO_INIT), .CNT_W(2)) u_dut2 (
    .clk (clk), .rst (rst),
    .req0_valid (req0_valid), .req0_a (req0_a), .req0_b (req0_b), .req0_ready (r0_ready2),
    .req1_valid (req1_valid), .req1_a (req1_a), .req1_b (req1_b), .req1_ready (r1_ready2),
    .rsp0_valid (s0_valid2), .rsp1_valid (s1_valid2), .rsp_ready (rsp_ready),
    .rsp_product (product2), .busy (busy2), .op_count (op_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_a = 0; m_b = 0; m_last = 0;
    m_prio = int'(PRIO_INIT); m_count = 0;
    l_rdy0 = 1'b0; l_rdy1 = 1'b0;
  endtask

  // Called just after a falling edge with inputs settled; checks, then
  // advances the model across the next rising edge.
  task automatic step();
    int  g;
    bit  resp;
    #1;
    g = -1;
    if (m_owner < 0) begin
      if (req0_valid && req1_valid) g = m_prio;
      else if (req1_valid)          g = 1;
      else if (req0_valid)          g = 0;
    end
    resp = (m_owner >= 0) && (m_age >= 2);
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(resp && m_owner == 0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(resp && m_owner == 1));
    chk("rsp_product", 32'(rsp_product), 32'(m_last));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("op_count", 32'(op_count), 32'(m_count % 256));
    chk("op_count_w2", 32'(op_count2), 32'(m_count % 4));
    l_rdy0 = (g == 0);
    l_rdy1 = (g == 1);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_owner = g;
      m_a = (g == 0) ? int'(req0_a) : int'(req1_a);
      m_b = (g == 0) ? int'(req0_b) : int'(req1_b);
      m_age = 1;
    end else if (m_owner >= 0 && m_age == 1) begin
      m_age = 2;
      m_last = m_a * m_b;
    end else if (resp && rsp_ready[m_owner]) begin
      m_count++;
      m_prio = 1 - m_owner;
      m_owner = -1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 2'b00;
  endtask

  task automatic sync_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 4'd2,  4'd3,  8'h06};
    tbl[1] = '{0, 4'd5,  4'd5,  8'h19};
    tbl[2] = '{1, 4'd6,  4'd3,  8'h12};
    tbl[3] = '{0, 4'd9,  4'd4,  8'h24};
    tbl[4] = '{1, 4'd15, 4'd15, 8'hE1};
    tbl[5] = '{0, 4'd0,  4'd15, 8'h00};
    tbl[6] = '{1, 4'd15, 4'd1,  8'h0F};
    tbl[7] = '{0, 4'd7,  4'd8,  8'h38};

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_product", 32'(rsp_product), 32'(0));
    chk("reset_count", 32'(op_count), 32'(0));
    chk("reset_rsp", 32'({rsp0_valid, rsp1_valid}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Vector table: one requester at a time, immediate response accept.
    for (int i = 0; i < 8; i++) begin
      rsp_ready = 2'b11;
      if (tbl[i].who == 0) begin
        req0_valid = 1'b1; req0_a = tbl[i].a; req0_b = tbl[i].b;
      end else begin
        req1_valid = 1'b1; req1_a = tbl[i].a; req1_b = tbl[i].b;
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      #1;
      chk("tbl_product", 32'(rsp_product), 32'(tbl[i].exp));
      chk("tbl_rsp_owner", 32'(tbl[i].who == 0 ? rsp0_valid : rsp1_valid), 32'(1));
      step();
      if (i == 0) chk("first_count", 32'(op_count), 32'(1));
    end

    // Fairness: both valid continuously, grants must alternate from prio 0.
    sync_reset();
    rsp_ready = 2'b11;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd3;
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      #1;
      chk("fair_owner", 32'(rsp1_valid), 32'(k % 2));
      chk("fair_product", 32'(rsp_product), (k % 2 == 0) ? 32'h19 : 32'h12);
      step();
    end
    clear_inputs();

    // Back-pressure: response held while req1 waits and rsp_ready[1] is ignored.
    sync_reset();
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4;
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
    rsp_ready = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_product", 32'(rsp_product), 32'h24);
      chk("bp_rsp0", 32'(rsp0_valid), 32'(1));
      chk("bp_req1_ready", 32'(req1_ready), 32'(0));
      step();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b11;
    repeat (3) step();
    clear_inputs();

    // Reset in RESP with prio=1: op dropped, prio back to initial value.
    sync_reset();
    rsp_ready = 2'b11;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2;
    repeat (3) step();
    req0_valid = 1'b0;
    rsp_ready = 2'b00;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7;
    step();
    req1_valid = 1'b0;
    step();
    rst = 1'b1; rsp_ready = 2'b11;
    step();
    rst = 1'b0; rsp_ready = 2'b00;
    #1;
    chk("rst_resp_rsp1", 32'(rsp1_valid), 32'(0));
    chk("rst_resp_busy", 32'(busy), 32'(0));
    chk("rst_resp_product", 32'(rsp_product), 32'(0));
    chk("rst_resp_count", 32'(op_count), 32'(0));
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_prio_init", 32'({req1_ready, req0_ready}), PRIO_INIT ? 32'h2 : 32'h1);
    clear_inputs();
    step();

    // Narrow counter wraps: 1,2,3,0,1.
    sync_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_a = 4'(k); req0_b = 4'd3;
      step();
      req0_valid = 1'b0;
      step();
      step();
      #1;
      chk("wrap_count", 32'(op_count2), 32'((k + 1) % 4));
    end

    // Randomized traffic; a requester holds valid/operands until accepted.
    sync_reset();
    for (int n = 0; n < 600; n++) begin
      if (!(req0_valid && !l_rdy0)) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = 4'($urandom); req0_b = 4'($urandom);
      end
      if (!(req1_valid && !l_rdy1)) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = 4'($urandom); req1_b = 4'($urandom);
      end
      rsp_ready = 2'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
